// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: FSM encoding, sizing helper and default parameters for mem_ctrl_wq
package mem_ctrl_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 8;
  localparam int WQ_DEPTH_DEF = 8;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RD_WAIT = 1'b1;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/mem_ctrl_wq_if.sv
// mem_ctrl_wq_if: posted-write and request/valid read bundle between requester and controller
interface mem_ctrl_wq_if import mem_ctrl_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int WQ_DEPTH = WQ_DEPTH_DEF
) ();
  localparam int LW = clog2(WQ_DEPTH) + 1;
  logic wr_valid;
  logic wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic rd_req;
  logic rd_ready;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic rd_valid;
  logic empty;
  logic full;
  logic [LW-1:0] wq_level;
  modport master (
    output wr_valid, wr_addr, wr_data, rd_req, rd_addr,
    input wr_ready, rd_ready, rd_data, rd_valid, empty, full, wq_level
  );
  modport slave (
    input wr_valid, wr_addr, wr_data, rd_req, rd_addr,
    output wr_ready, rd_ready, rd_data, rd_valid, empty, full, wq_level
  );
endinterface

// File: rtl/wq_sync_fifo.sv
// wq_sync_fifo: single-clock first-word-fall-through FIFO with registered level/empty/full
module wq_sync_fifo import mem_ctrl_pkg::*; #(
  parameter int W = 16,
  parameter int DEPTH = 8,
  localparam int PW = clog2(DEPTH)
) (
  input logic clk,
  input logic reset,
  input logic push,
  input logic pop,
  input logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic empty,
  output logic full,
  output logic [PW:0] level
);
  logic [W-1:0] mem [DEPTH];
  logic [PW-1:0] wp, rp;
  logic do_push, do_pop;
  logic [PW:0] nxt;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem[rp];
  assign nxt = level + (PW+1)'(do_push) - (PW+1)'(do_pop);
  always_ff @(posedge clk)
    if (!reset) begin
      wp <= '0;
      rp <= '0;
      level <= '0;
      empty <= 1'b1;
      full <= 1'b0;
    end else begin
      if (do_push) wp <= wp + PW'(1);
      if (do_pop) rp <= rp + PW'(1);
      level <= nxt;
      empty <= nxt == '0;
      full <= nxt == (PW+1)'(DEPTH);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
endmodule

// File: rtl/mem_ctrl_wq.sv
// mem_ctrl_wq: block RAM behind a posted write queue; reads admitted only once the queue is drained
module mem_ctrl_wq import mem_ctrl_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int WQ_DEPTH = WQ_DEPTH_DEF
) (
  input logic clk_mem,
  input logic reset,
  mem_ctrl_wq_if.slave bus
);
  localparam int EW = ADDR_W + DATA_W;
  logic [0:0] state;
  logic [DATA_W-1:0] ram [2**ADDR_W];
  logic [DATA_W-1:0] ram_q;
  logic [EW-1:0] head;
  logic pop, rd_go;
  assign bus.rd_ready = state == IDLE && bus.empty;
  assign bus.wr_ready = !bus.full;
  assign pop = state == IDLE && !bus.empty;
  assign rd_go = bus.rd_ready && bus.rd_req;
  wq_sync_fifo #(.W(EW), .DEPTH(WQ_DEPTH)) u_fifo (
    .clk(clk_mem),
    .reset,
    .push(bus.wr_valid),
    .pop,
    .din({bus.wr_addr, bus.wr_data}),
    .dout(head),
    .empty(bus.empty),
    .full(bus.full),
    .level(bus.wq_level)
  );
  // pop is gated by reset so a discarded queue head never reaches the RAM
  always_ff @(posedge clk_mem) begin
    if (reset && pop) ram[head[EW-1:DATA_W]] <= head[DATA_W-1:0];
    if (rd_go) ram_q <= ram[bus.rd_addr];
  end
  always_ff @(posedge clk_mem)
    if (!reset) begin
      state <= IDLE;
      bus.rd_valid <= 1'b0;
      bus.rd_data <= '0;
    end else begin
      state <= rd_go ? RD_WAIT : IDLE;
      bus.rd_valid <= state == RD_WAIT;
      if (state == RD_WAIT) bus.rd_data <= ram_q;
    end
endmodule
